// File: rtl/branch_steer_unit.sv
// Front-end steering for the RV32I pipeline: BTB-based next-PC prediction,
// ID operand selection, and EX next-PC / misprediction redirect.
`ifndef BRANCH_STEER_DEFS
`define BRANCH_STEER_DEFS
`define OP_TYPE_NONE 2'd0
`define OP_TYPE_REG  2'd1
`define OP_TYPE_IMM  2'd2
`define OP_TYPE_PC   2'd3
`define ALU_ADD      6'd0
`define ALU_JAL      6'd1
`define ALU_JALR     6'd2
`define ALU_BEQ      6'd3
`define ALU_BNE      6'd4
`define ALU_BLT      6'd5
`define ALU_BGE      6'd6
`define ALU_BLTU     6'd7
`define ALU_BGEU     6'd8
`endif

module branch_steer_unit #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 14 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic [31:0] if_npc_pred,
    input  logic [31:0] id_pc,
    input  logic [1:0]  id_aluop1_type,
    input  logic [1:0]  id_aluop2_type,
    input  logic [31:0] id_regdata1,
    input  logic [31:0] id_regdata2,
    input  logic [31:0] id_imm,
    output logic [31:0] id_oprl,
    output logic [31:0] id_oprr,
    input  logic [31:0] ex_pc,
    input  logic [5:0]  ex_alucode,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_regdata1,
    input  logic        ex_br_taken,
    output logic [31:0] ex_npc,
    output logic        ex_redirect
);

    localparam int ENTRIES = 1 << IDX_W;

    // valid/ctr are control and get reset; tag/target are only meaningful when valid
    logic             btb_valid  [ENTRIES];
    logic [1:0]       btb_ctr    [ENTRIES];
    logic [TAG_W-1:0] btb_tag    [ENTRIES];
    logic [15:0]      btb_target [ENTRIES];

    function automatic logic [31:0] sel_operand(input logic [1:0]  op_type,
                                                input logic [31:0] reg_val,
                                                input logic [31:0] imm_val,
                                                input logic [31:0] pc_val);
        case (op_type)
            `OP_TYPE_REG: return reg_val;
            `OP_TYPE_IMM: return imm_val;
            `OP_TYPE_PC:  return pc_val;
            default:      return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : 2'(c + 2'd1);
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : 2'(c - 2'd1);
    endfunction

    // ID: operand select
    assign id_oprl = sel_operand(id_aluop1_type, id_regdata1, id_imm, id_pc);
    assign id_oprr = sel_operand(id_aluop2_type, id_regdata2, id_imm, id_pc);

    // IF: prediction lookup, sees pre-update contents on a same-cycle write
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[15:IDX_W+2];
    assign if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    assign if_npc_pred = (if_hit && btb_ctr[if_idx][1]) ? {16'd0, btb_target[if_idx]}
                                                        : if_pc + 32'd4;

    // EX: actual next PC and redirect
    logic [31:0] ex_pc_plus4;
    logic [31:0] ex_pc_plus_imm;
    logic [31:0] ex_jalr_sum;

    assign ex_pc_plus4    = ex_pc + 32'd4;
    assign ex_pc_plus_imm = ex_pc + ex_imm;
    assign ex_jalr_sum    = ex_regdata1 + ex_imm;

    always_comb begin
        ex_npc = ex_pc_plus4;
        case (ex_alucode)
            `ALU_JAL:  ex_npc = ex_pc_plus_imm;
            `ALU_JALR: ex_npc = {ex_jalr_sum[31:1], 1'b0};
            `ALU_BEQ, `ALU_BNE, `ALU_BLT, `ALU_BGE, `ALU_BLTU, `ALU_BGEU:
                ex_npc = ex_br_taken ? ex_pc_plus_imm : ex_pc_plus4;
            default:   ex_npc = ex_pc_plus4;
        endcase
    end

    assign ex_redirect = (ex_pc != 32'd0) && (id_pc != 32'd0) && (ex_npc != id_pc);

    // BTB training from the resolved EX instruction
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             ex_taken;
    logic             ex_live;

    assign ex_idx   = ex_pc[IDX_W+1:2];
    assign ex_tag   = ex_pc[15:IDX_W+2];
    assign ex_hit   = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    assign ex_taken = (ex_npc != ex_pc_plus4);
    assign ex_live  = (ex_pc != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'd0;
            end
        end else if (ex_live) begin
            if (ex_hit) begin
                btb_ctr[ex_idx] <= ex_taken ? sat_inc(btb_ctr[ex_idx]) : sat_dec(btb_ctr[ex_idx]);
            end else if (ex_taken) begin
                btb_valid[ex_idx] <= 1'b1;
                btb_ctr[ex_idx]   <= 2'd2;
            end
        end
    end

    // Tag is unchanged on a hit, so hit-taken and allocate share one write
    always_ff @(posedge clk) begin
        if (ex_live && ex_taken) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= ex_npc[15:0];
        end
    end

endmodule

// File: tb/tb_branch_steer_unit.sv
// Testbench for branch_steer_unit: directed literal checks plus randomized
// traffic compared every cycle against a behavioural BTB/next-PC model.
module tb_branch_steer_unit;

    localparam logic [1:0] T_NONE = 2'd0, T_REG = 2'd1, T_IMM = 2'd2, T_PC = 2'd3;
    localparam logic [5:0] A_ADD = 6'd0, A_JAL = 6'd1, A_JALR = 6'd2, A_BEQ = 6'd3,
                           A_BNE = 6'd4, A_BLT = 6'd5, A_BGE = 6'd6, A_BLTU = 6'd7,
                           A_BGEU = 6'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc, if_npc_pred;
    logic [31:0] id_pc;
    logic [1:0]  id_aluop1_type, id_aluop2_type;
    logic [31:0] id_regdata1, id_regdata2, id_imm, id_oprl, id_oprr;
    logic [31:0] ex_pc;
    logic [5:0]  ex_alucode;
    logic [31:0] ex_imm, ex_regdata1, ex_npc;
    logic        ex_br_taken, ex_redirect;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    branch_steer_unit dut (
        .clk(clk), .rst(rst),
        .if_pc(if_pc), .if_npc_pred(if_npc_pred),
        .id_pc(id_pc), .id_aluop1_type(id_aluop1_type), .id_aluop2_type(id_aluop2_type),
        .id_regdata1(id_regdata1), .id_regdata2(id_regdata2), .id_imm(id_imm),
        .id_oprl(id_oprl), .id_oprr(id_oprr),
        .ex_pc(ex_pc), .ex_alucode(ex_alucode), .ex_imm(ex_imm),
        .ex_regdata1(ex_regdata1), .ex_br_taken(ex_br_taken),
        .ex_npc(ex_npc), .ex_redirect(ex_redirect)
    );

    always #5 clk = ~clk;

    // Behavioural BTB: 64 entries, index pc[7:2], tag pc[15:8]
    bit          m_valid [64];
    logic [7:0]  m_tag   [64];
    logic [15:0] m_tgt   [64];
    int          m_ctr   [64];

    function automatic logic [31:0] model_npc(logic [5:0] code, logic [31:0] pc,
                                              logic [31:0] imm, logic [31:0] rs1, logic bt);
        logic [31:0] s;
        if (code == A_JAL) return pc + imm;
        if (code == A_JALR) begin
            s = rs1 + imm;
            return s & 32'hFFFF_FFFE;
        end
        if (code >= A_BEQ && code <= A_BGEU) return bt ? pc + imm : pc + 32'd4;
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] model_opr(logic [1:0] t, logic [31:0] r,
                                              logic [31:0] imm, logic [31:0] pc);
        if (t == T_REG) return r;
        if (t == T_IMM) return imm;
        if (t == T_PC)  return pc;
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_pred(logic [31:0] pc);
        int idx = int'((pc >> 2) & 32'd63);
        logic [7:0] tg = pc[15:8];
        if (m_valid[idx] && m_tag[idx] == tg && m_ctr[idx] >= 2) return {16'd0, m_tgt[idx]};
        return pc + 32'd4;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the clock edge, from the inputs held across it
    always @(posedge clk) begin : model_update
        logic [31:0] n;
        int idx;
        bit hit, tk;
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] <= 1'b0;
                m_ctr[i]   <= 0;
            end
        end else if (ex_pc != 32'd0) begin
            n   = model_npc(ex_alucode, ex_pc, ex_imm, ex_regdata1, ex_br_taken);
            tk  = (n != ex_pc + 32'd4);
            idx = int'((ex_pc >> 2) & 32'd63);
            hit = m_valid[idx] && (m_tag[idx] == ex_pc[15:8]);
            if (hit && tk) begin
                m_ctr[idx] <= (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                m_tgt[idx] <= n[15:0];
            end else if (hit) begin
                m_ctr[idx] <= (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            end else if (tk) begin
                m_valid[idx] <= 1'b1;
                m_tag[idx]   <= ex_pc[15:8];
                m_tgt[idx]   <= n[15:0];
                m_ctr[idx]   <= 2;
            end
        end
    end

    // Compare all outputs against the model every cycle once reset has run
    always @(negedge clk) begin
        logic [31:0] en;
        if (cmp_en) begin
            en = model_npc(ex_alucode, ex_pc, ex_imm, ex_regdata1, ex_br_taken);
            chk("pred",     if_npc_pred, model_pred(if_pc));
            chk("oprl",     id_oprl, model_opr(id_aluop1_type, id_regdata1, id_imm, id_pc));
            chk("oprr",     id_oprr, model_opr(id_aluop2_type, id_regdata2, id_imm, id_pc));
            chk("npc",      ex_npc, en);
            chk("redirect", {31'd0, ex_redirect},
                {31'd0, (ex_pc != 0) && (id_pc != 0) && (en != id_pc)});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex;
        ex_pc = 32'd0; ex_alucode = A_ADD; ex_imm = 32'd0;
        ex_regdata1 = 32'd0; ex_br_taken = 1'b0;
    endtask

    task automatic train(logic [31:0] pc, bit taken_jal, logic [31:0] imm);
        ex_pc = pc; ex_alucode = taken_jal ? A_JAL : A_ADD; ex_imm = imm;
        tick;
        idle_ex;
    endtask

    task automatic look(string name, logic [31:0] pc, logic [31:0] exp);
        if_pc = pc;
        #1;
        chk(name, if_npc_pred, exp);
    endtask

    function automatic logic [31:0] pool_pc();
        return 32'h8000 | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 7) << 2);
    endfunction

    function automatic logic [31:0] small_imm();
        return 32'($signed($urandom_range(0, 31) * 4) - 64);
    endfunction

    initial begin
        logic [5:0] codes [10];
        codes = '{A_ADD, A_JAL, A_JALR, A_BEQ, A_BNE, A_BLT, A_BGE, A_BLTU, A_BGEU, 6'd20};
        rst = 1'b1; if_pc = 32'h8000; id_pc = 32'd0;
        id_aluop1_type = T_NONE; id_aluop2_type = T_NONE;
        id_regdata1 = 32'd0; id_regdata2 = 32'd0; id_imm = 32'd0;
        idle_ex;
        tick; tick;
        rst = 1'b0;
        cmp_en = 1'b1;

        // Operand select
        id_pc = 32'h8010; id_regdata1 = 32'd5; id_regdata2 = 32'd7; id_imm = 32'hFFFF_FFFC;
        id_aluop1_type = T_REG; id_aluop2_type = T_IMM; #1;
        chk("sel_reg_l", id_oprl, 32'd5);
        chk("sel_imm_r", id_oprr, 32'hFFFF_FFFC);
        id_aluop1_type = T_PC; id_aluop2_type = T_REG; #1;
        chk("sel_pc_l", id_oprl, 32'h8010);
        chk("sel_reg_r", id_oprr, 32'd7);
        id_aluop1_type = T_NONE; id_aluop2_type = T_NONE; #1;
        chk("sel_none_l", id_oprl, 32'd0);
        chk("sel_none_r", id_oprr, 32'd0);

        // Next-PC generation and redirect (combinational, same cycle)
        ex_pc = 32'h8100; ex_imm = 32'h20; ex_alucode = A_BEQ; ex_br_taken = 1'b1;
        id_pc = 32'h8104; #1;
        chk("beq_taken", ex_npc, 32'h8120);
        chk("redir_on", {31'd0, ex_redirect}, 32'd1);
        ex_br_taken = 1'b0; #1;
        chk("beq_not", ex_npc, 32'h8104);
        chk("redir_off", {31'd0, ex_redirect}, 32'd0);
        ex_alucode = A_JALR; ex_regdata1 = 32'h9001; ex_imm = 32'd4; #1;
        chk("jalr", ex_npc, 32'h9004);
        ex_alucode = A_JAL; ex_imm = 32'hFFFF_FFF0; #1;
        chk("jal_neg", ex_npc, 32'h80F0);
        ex_alucode = A_ADD; #1;
        chk("add_seq", ex_npc, 32'h8104);
        ex_alucode = A_JAL; ex_imm = 32'h20; id_pc = 32'd0; #1;
        chk("redir_id0", {31'd0, ex_redirect}, 32'd0);
        id_pc = 32'h8104; ex_pc = 32'd0; #1;
        chk("redir_ex0", {31'd0, ex_redirect}, 32'd0);
        idle_ex; id_pc = 32'd0;

        // BTB train/predict after reset
        rst = 1'b1; tick; rst = 1'b0;
        look("cold", 32'h8200, 32'h8204);
        look("cold_hi", 32'hABCD_8200, 32'hABCD_8204);
        ex_pc = 32'h8200; ex_alucode = A_JAL; ex_imm = 32'h100;
        look("same_cyc", 32'h8200, 32'h8204);
        tick; idle_ex;
        look("trained", 32'h8200, 32'h8300);
        look("hi_ignored", 32'h1234_8200, 32'h8300);

        // Hysteresis: ctr 2 -> 3 (saturate) -> down
        train(32'h8200, 1, 32'h100); train(32'h8200, 1, 32'h100);
        train(32'h8200, 0, 32'd0);
        look("ctr2_after_dec", 32'h8200, 32'h8300);
        train(32'h8200, 0, 32'd0);
        look("ctr1_fall", 32'h8200, 32'h8204);
        train(32'h8200, 1, 32'h100);
        look("ctr2_again", 32'h8200, 32'h8300);
        train(32'h8200, 0, 32'd0); train(32'h8200, 0, 32'd0);
        train(32'h8200, 0, 32'd0); train(32'h8200, 0, 32'd0);
        train(32'h8200, 1, 32'h100);
        look("sat0_ctr1", 32'h8200, 32'h8204);
        train(32'h8200, 1, 32'h100);
        look("sat0_ctr2", 32'h8200, 32'h8300);

        // Conflict: 0x8300 shares index 0 with 0x8200
        train(32'h8300, 1, 32'h100);
        look("evicted", 32'h8200, 32'h8204);
        look("new_owner", 32'h8300, 32'h8400);

        // Reset clears, and a concurrent update is dropped
        rst = 1'b1; ex_pc = 32'h8200; ex_alucode = A_JAL; ex_imm = 32'h100;
        tick; rst = 1'b0; idle_ex;
        look("rst_clr_a", 32'h8300, 32'h8304);
        look("rst_clr_b", 32'h8200, 32'h8204);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if_pc = pool_pc();
            if ($urandom_range(0, 3) == 0) if_pc[31:16] = 16'($urandom());
            ex_pc = ($urandom_range(0, 7) == 0) ? 32'd0 : pool_pc();
            ex_alucode = codes[$urandom_range(0, 9)];
            ex_imm = small_imm();
            ex_regdata1 = pool_pc() | 32'($urandom_range(0, 1));
            ex_br_taken = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: id_pc = 32'd0;
                1: id_pc = model_npc(ex_alucode, ex_pc, ex_imm, ex_regdata1, ex_br_taken);
                default: id_pc = pool_pc();
            endcase
            id_aluop1_type = 2'($urandom_range(0, 3));
            id_aluop2_type = 2'($urandom_range(0, 3));
            id_regdata1 = $urandom(); id_regdata2 = $urandom(); id_imm = $urandom();
            tick;
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_steer_unit.md
Name: branch_steer_unit

Overview:
- Front-end steering block for the 5-stage RV32I pipeline. Combines three functions:
  - IF-stage next-PC prediction from a direct-mapped branch target buffer (BTB) with 2-bit counters.
  - ID-stage ALU operand selection.
  - EX-stage actual next-PC computation and misprediction detection.
- The EX result also trains the BTB internally.

Parameters:
- IDX_W, 6, log2 of BTB entries (64 entries); index = pc[IDX_W+1:2].
- TAG_W, 14-IDX_W, tag width; tag = pc[15:IDX_W+2].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  32  PC being fetched.
- if_npc_pred  out  32  predicted next fetch PC.
- id_pc  in  32  ID-stage PC; 0 = bubble.
- id_aluop1_type  in  2  `OP_TYPE_* select for left operand.
- id_aluop2_type  in  2  `OP_TYPE_* select for right operand.
- id_regdata1  in  32  rs1 value.
- id_regdata2  in  32  rs2 value.
- id_imm  in  32  decoded immediate.
- id_oprl  out  32  left ALU operand.
- id_oprr  out  32  right ALU operand.
- ex_pc  in  32  EX-stage PC; 0 = bubble.
- ex_alucode  in  6  `ALU_* code of EX instruction.
- ex_imm  in  32  EX immediate.
- ex_regdata1  in  32  forwarded rs1 in EX.
- ex_br_taken  in  1  ALU compare result for conditional branches.
- ex_npc  out  32  actual next PC.
- ex_redirect  out  1  misprediction flush request.

Behaviour:
- All outputs are combinational. Only the BTB holds state.

Operand select (per side):
- `OP_TYPE_REG selects id_regdata1 (left) or id_regdata2 (right).
- `OP_TYPE_IMM selects id_imm.
- `OP_TYPE_PC selects id_pc.
- `OP_TYPE_NONE or any other encoding gives 0.

Next-PC generation:
- `ALU_JAL: ex_pc+ex_imm.
- `ALU_JALR: (ex_regdata1+ex_imm) with bit0 cleared.
- `ALU_BEQ/BNE/BLT/BGE/BLTU/BGEU: ex_pc+ex_imm if ex_br_taken, else ex_pc+4.
- All other codes: ex_pc+4.
- Arithmetic is 32-bit modulo 2^32 with wrap-around.

Redirect:
- ex_redirect = (ex_pc!=0) && (id_pc!=0) && (ex_npc!=id_pc).

BTB entry: valid bit, tag[TAG_W], target[16], ctr[2].

Prediction lookup:
- Hit = valid && tag match on if_pc[15:0].
- If hit and ctr>=2: if_npc_pred = {16'b0, target}.
- Otherwise: if_npc_pred = if_pc+4 (full 32-bit).
- Bits if_pc[31:16] are ignored for lookup.

Training, at posedge clk when rst=0 and ex_pc!=0:
- taken = (ex_npc != ex_pc+4). Entry index and tag come from ex_pc[15:0].
- Hit and taken: ctr saturating +1 (max 3); target <= ex_npc[15:0].
- Hit and not taken: ctr saturating -1 (min 0); target unchanged.
- Miss and taken: allocate, overwriting any entry: valid=1, tag, target=ex_npc[15:0], ctr=2.
- Miss and not taken: no change.
- ex_pc==0: no update.

Timing:
- Same-cycle lookup and update of one entry: the lookup returns the pre-update contents. The new value is visible the next cycle.

Reset:
- Synchronous. Clears all valid bits and ctr=0.
- Takes priority over training. Targets and tags are don't-care.
- After reset, if_npc_pred = if_pc+4 for every PC.
- Reset mid-operation discards training from that cycle.

Test Plan:
1. Operand select: id_pc=0x8010, id_regdata1=5, id_regdata2=7, id_imm=0xFFFFFFFC.
   - types REG/IMM -> oprl=5, oprr=0xFFFFFFFC.
   - types PC/REG -> oprl=0x8010, oprr=7.
   - types NONE/NONE -> 0/0.
2. NPC generation:
   - BEQ, ex_pc=0x8100, ex_imm=0x20: taken -> ex_npc=0x8120; not taken -> 0x8104.
   - JALR, ex_regdata1=0x9001, ex_imm=4 -> 0x9004.
   - JAL, ex_imm=0xFFFFFFF0 -> 0x80F0.
   - ADD -> 0x8104.
3. Redirect:
   - id_pc=0x8104, ex_npc=0x8104 -> 0.
   - id_pc=0x8104, ex_npc=0x8120 -> 1.
   - ex_pc=0 or id_pc=0 -> 0.
4. BTB train/predict, after reset:
   - if_pc=0x8200 -> 0x8204.
   - One taken JAL at ex_pc=0x8200 to 0x8300, then if_pc=0x8200 -> 0x8300.
   - Same cycle as the training update -> still 0x8204.
5. Hysteresis:
   - Entry ctr=3; two not-taken updates (ctr 1) -> predicts fallthrough.
   - One taken -> ctr 2 -> predicts target again.
   - Counter saturates at 0 and 3.
6. Conflict and reset:
   - 0x8200 and 0x8300 share an index (IDX_W=6); a taken branch at 0x8300 evicts 0x8200, which then predicts 0x8204.
   - Asserting rst for one cycle clears all entries.
   - An update presented during rst is ignored.
